// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencing controller: Moore FSM stepping each instruction
// through fetch/decode/execute/memory/write-back, with memory stalls and a retire counter.
module multicycle_control #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [10:0]            opcode,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   ir_write,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   i_or_d,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   reg_to_loc,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   pc_source,
  output logic [3:0]             state,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    HALT      = 4'd11
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] retired_reg;
  logic                   retire;

  logic is_ldur, is_stur, is_rtype, is_cbz, is_b, in_sequence;

  assign is_ldur  = (opcode == 11'b11111000010);
  assign is_stur  = (opcode == 11'b11111000000);
  assign is_rtype = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                    (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
  assign is_cbz   = (opcode[10:3] == 8'b10110100);
  assign is_b     = (opcode[10:5] == 6'b000101);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        retired_reg <= retired_reg + COUNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 1'b0;
    halted        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        // IR and PC+4 commit only on the cycle the instruction word arrives
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (is_ldur || is_stur) state_next = MEM_ADDR;
        else if (is_rtype)      state_next = R_EXEC;
        else if (is_cbz)        state_next = BRANCH;
        else if (is_b)          state_next = JUMP;
        else                    state_next = HALT;
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = is_ldur ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_next = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        retire        = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 1'b1;
        retire    = 1'b1;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = HALT;
      end
    endcase
    if (retire) state_next = run ? FETCH : IDLE;
  end

  // reg_to_loc follows the opcode directly, but stays quiet while parked
  assign in_sequence = (state_reg >= FETCH) && (state_reg <= JUMP);
  assign reg_to_loc  = in_sequence && (is_stur || is_cbz);
  assign state       = state_reg;
  assign retired     = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: path-queue reference model plus
// directed scenarios and randomized run/mem_ready/opcode stimulus.
module tb_multicycle_control;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010110011;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
  } ctrl_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [10:0] opcode = 11'd0;

  logic pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
  logic reg_write, mem_to_reg, reg_to_loc, alu_src_a, pc_source, halted;
  logic [1:0]  alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] retired;

  logic w4_pc_write, w4_pc_write_cond, w4_ir_write, w4_mem_read, w4_mem_write, w4_i_or_d;
  logic w4_reg_write, w4_mem_to_reg, w4_reg_to_loc, w4_alu_src_a, w4_pc_source, w4_halted;
  logic [1:0] w4_alu_src_b, w4_alu_op;
  logic [3:0] w4_state;
  logic [3:0] w4_retired;

  multicycle_control #(.COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_to_loc(reg_to_loc),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .halted(halted), .retired(retired)
  );

  multicycle_control #(.COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(w4_pc_write), .pc_write_cond(w4_pc_write_cond), .ir_write(w4_ir_write),
    .mem_read(w4_mem_read), .mem_write(w4_mem_write), .i_or_d(w4_i_or_d),
    .reg_write(w4_reg_write), .mem_to_reg(w4_mem_to_reg), .reg_to_loc(w4_reg_to_loc),
    .alu_src_a(w4_alu_src_a), .alu_src_b(w4_alu_src_b), .alu_op(w4_alu_op),
    .pc_source(w4_pc_source), .state(w4_state), .halted(w4_halted), .retired(w4_retired)
  );

  always #5 clock = ~clock;

  ctrl_t act_c;
  assign act_c = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                  reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an instruction is FETCH, DECODE, then a list of phases
  // chosen by its class; it retires after the last phase. Memory phases wait.
  int          m_state = 0;
  int          path[$];
  logic [31:0] m_ret = 32'd0;

  task automatic plan_route(input logic [10:0] op);
    path.delete();
    casez (op)
      OP_LDUR:                         begin path.push_back(3); path.push_back(4); path.push_back(5); end
      OP_STUR:                         begin path.push_back(3); path.push_back(6); end
      OP_ADD, OP_SUB, OP_AND, OP_ORR:  begin path.push_back(7); path.push_back(8); end
      11'b10110100???:                 path.push_back(9);
      11'b000101?????:                 path.push_back(10);
      default:                         path.push_back(11);
    endcase
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state = 0;
      m_ret   = 32'd0;
      path.delete();
    end else begin
      case (m_state)
        0:  if (run) m_state = 1;
        1:  if (mem_ready) m_state = 2;
        2:  begin plan_route(opcode); m_state = path.pop_front(); end
        11: m_state = 11;
        default: begin
          if (!((m_state == 4 || m_state == 6) && !mem_ready)) begin
            if (path.size() > 0) m_state = path.pop_front();
            else begin
              m_ret++;
              m_state = run ? 1 : 0;
            end
          end
        end
      endcase
    end
  end

  function automatic ctrl_t expect_ctrl(input int s, input logic mr);
    ctrl_t c;
    c = '0;
    case (s)
      1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      2:  c.alu_src_b = 2'b11;
      3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4:  begin c.mem_read = 1; c.i_or_d = 1; end
      5:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      6:  begin c.mem_write = 1; c.i_or_d = 1; end
      7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      8:  c.reg_write = 1;
      9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 1; end
      10: begin c.pc_write = 1; c.pc_source = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    #2;
    check("state", {28'd0, state}, m_state);
    check("ctrl", {18'd0, act_c}, {18'd0, expect_ctrl(m_state, mem_ready)});
    check("reg_to_loc", {31'd0, reg_to_loc},
          {31'd0, (m_state >= 1 && m_state <= 10) &&
                  (opcode == OP_STUR || opcode[10:3] == 8'b10110100)});
    check("halted", {31'd0, halted}, {31'd0, m_state == 11});
    check("retired", retired, m_ret);
    check("state_w4", {28'd0, w4_state}, m_state);
    check("retired_w4", {28'd0, w4_retired}, {28'd0, m_ret[3:0]});
  end

  task automatic drive(input logic r, input logic mr, input logic [10:0] op);
    @(negedge clock);
    run = r;
    mem_ready = mr;
    opcode = op;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic logic [10:0] pick_opcode();
    logic [10:0] op;
    case ($urandom_range(0, 8))
      0: op = OP_LDUR;
      1: op = OP_STUR;
      2: op = OP_ADD;
      3: op = OP_SUB;
      4: op = OP_AND;
      5: op = OP_ORR;
      6: op = {8'b10110100, 3'($urandom_range(0, 7))};
      7: op = {6'b000101, 5'($urandom_range(0, 31))};
      default: op = ($urandom_range(0, 9) == 0) ? 11'($urandom) : OP_ADD;
    endcase
    return op;
  endfunction

  initial begin
    int add_seq[5] = '{1, 2, 7, 8, 1};
    int ld_pat[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int active, rd_cnt, m2r_cnt, pcwc_cnt;
    logic [10:0] op;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_ctrl", {18'd0, act_c}, 32'd0);
    check("rst_retired", retired, 32'd0);

    // ADD with zero-wait memory, then run dropped during R_EXEC
    do_reset();
    drive(1, 1, OP_ADD);
    check("add_idle", {28'd0, state}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, OP_ADD);
      check("add_seq", {28'd0, state}, add_seq[k]);
      check("add_reg_write", {31'd0, reg_write}, {31'd0, k == 3});
      if (k == 2) check("add_alu_op", {30'd0, alu_op}, 32'd2);
    end
    check("add_retired", retired, 32'd1);
    check("model_ret_add", m_ret, 32'd1);
    drive(1, 1, OP_ADD); check("drop_dec", {28'd0, state}, 32'd2);
    drive(0, 1, OP_ADD); check("drop_rex", {28'd0, state}, 32'd7);
    drive(0, 1, OP_ADD); check("drop_rwb", {28'd0, state}, 32'd8);
    drive(0, 1, OP_ADD); check("drop_idle", {28'd0, state}, 32'd0);
    check("drop_retired", retired, 32'd2);
    drive(1, 1, OP_ADD); check("rerun_idle", {28'd0, state}, 32'd0);
    drive(1, 1, OP_ADD); check("rerun_fetch", {28'd0, state}, 32'd1);

    // LDUR with two wait cycles in MEM_READ
    do_reset();
    drive(1, 1, OP_LDUR);
    active = 0; rd_cnt = 0; m2r_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      drive(0, ld_pat[k][0], OP_LDUR);
      if (state != 4'd0) active++;
      if (mem_read && i_or_d) rd_cnt++;
      if (state == 4'd5 && mem_to_reg) m2r_cnt++;
    end
    check("ldur_cycles", active, 32'd7);
    check("ldur_rd_hold", rd_cnt, 32'd3);
    check("ldur_mem_to_reg", m2r_cnt, 32'd1);
    check("ldur_retired", retired, 32'd1);

    // STUR then CBZ
    do_reset();
    pcwc_cnt = 0;
    drive(1, 1, OP_STUR);
    drive(1, 1, OP_STUR); check("stur_fetch", {28'd0, state}, 32'd1);
    drive(1, 1, OP_STUR); check("stur_dec", {28'd0, state}, 32'd2);
    drive(1, 1, OP_STUR); check("stur_r2l_addr", {31'd0, reg_to_loc}, 32'd1);
    drive(1, 1, OP_STUR); check("stur_r2l_wr", {31'd0, reg_to_loc}, 32'd1);
    check("stur_state", {28'd0, state}, 32'd6);
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 1, OP_CBZ);
      if (pc_write_cond) pcwc_cnt++;
      if (k == 2) begin
        check("cbz_r2l", {31'd0, reg_to_loc}, 32'd1);
        check("cbz_pc_source", {31'd0, pc_source}, 32'd1);
      end
    end
    check("cbz_pcwc_once", pcwc_cnt, 32'd1);
    check("stur_cbz_retired", retired, 32'd2);

    // Unknown opcode halts; run is ignored; async reset clears
    do_reset();
    drive(1, 1, OP_BAD);
    drive(1, 1, OP_BAD);
    drive(1, 1, OP_BAD);
    drive(1, 1, OP_BAD); check("halt_state", {28'd0, state}, 32'd11);
    check("halt_flag", {31'd0, halted}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(k[0], 1, OP_BAD);
      check("halt_sticky", {28'd0, state}, 32'd11);
    end
    check("halt_retired", retired, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("halt_rst_state", {28'd0, state}, 32'd0);
    check("halt_rst_flag", {31'd0, halted}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Counter wrap with a 4-bit counter: 16 B instructions
    do_reset();
    drive(1, 1, OP_B);
    for (int k = 0; k < 48; k++) drive(1, 1, OP_B);
    check("wrap_w4_15", {28'd0, w4_retired}, 32'd15);
    drive(1, 1, OP_B);
    check("wrap_w4_0", {28'd0, w4_retired}, 32'd0);
    check("wrap_w32_16", retired, 32'd16);

    // Async reset asserted mid-FETCH
    do_reset();
    drive(1, 0, OP_ADD);
    drive(1, 0, OP_ADD);
    check("stall_fetch_rd", {31'd0, mem_read}, 32'd1);
    check("stall_fetch_ir", {31'd0, ir_write}, 32'd0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_state", {28'd0, state}, 32'd0);
    check("async_ctrl", {18'd0, act_c}, 32'd0);
    check("async_retired", retired, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Randomized traffic
    op = OP_ADD;
    for (int i = 0; i < 3000; i++) begin
      if ((m_state == 11 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        if (m_state == 0 || m_state == 1) op = pick_opcode();
        drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70, op);
      end
    end

    @(negedge clock);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the LEGv8 datapath: a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back over 3–5+ cycles. It shares one unified memory between instruction fetch and data access. It drives the PC, instruction-register, register-bank, ALU-mux and memory enables each cycle. It sits between the instruction register's opcode field and the datapath control pins, and adds memory-ready stalling, a run gate and a retired-instruction counter.

## Interface
- COUNT_WIDTH, 32, width of retired-instruction counter
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low; forces IDLE and clears the counter
- run  in  1  start/continue request, sampled in IDLE and at instruction retire
- opcode  in  11  instruction[31:21] from the instruction register
- mem_ready  in  1  memory completion for the current mem_read/mem_write
- pc_write, pc_write_cond, ir_write  out  1 each  PC / conditional-PC / IR load enables
- mem_read, mem_write, i_or_d  out  1 each  memory strobes; i_or_d=1 selects the ALUOut address
- reg_write, mem_to_reg, reg_to_loc  out  1 each  register-bank controls
- alu_src_a  out  1  0=PC, 1=reg_data_1
- alu_src_b  out  2  00=reg_data_2, 01=const 4, 10=sign-extend, 11=sign-extend<<2
- alu_op  out  2  00=add, 01=pass B (zero test), 10=funct decode
- pc_source  out  1  0=ALU result, 1=ALUOut register
- state  out  4  current state encoding (debug)
- halted  out  1  high in HALT
- retired  out  COUNT_WIDTH  count of completed instructions

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, HALT=11. Codes 12–15 go to HALT.
- Outputs are Moore, decoded from state only. Exceptions: ir_write and pc_write in FETCH are gated by mem_ready, and reg_to_loc is taken directly from opcode. Any output not listed for a state is 0.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0, ir_write=pc_write=mem_ready. Hold until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target latched into ALUOut). Dispatch on opcode:
  - LDUR 11111000010 and STUR 11111000000 → MEM_ADDR.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 → R_EXEC.
  - CBZ 10110100xxx → BRANCH.
  - B 000101xxxxx → JUMP.
  - Anything else → HALT.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ for LDUR, MEM_WRITE for STUR.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Retire.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then retire.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, mem_to_reg=0. Retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1. Retire.
- JUMP: pc_write=1, pc_source=1. Retire.
- reg_to_loc=1 when opcode is STUR or CBZ, else 0.
- Retire: retired increments by 1 (wraps modulo 2^COUNT_WIDTH). Next state is FETCH if run=1, else IDLE.
- HALT: all control outputs 0, halted=1. Sticky until reset; run is ignored.

## Timing
- Reset (async assert, any state): state=IDLE, every output 0, retired=0. Deassertion takes effect at the next clock edge.
- Cycles per instruction with zero-wait memory (mem_ready high in the first cycle of each memory state):
  - R-type 4, LDUR 5, STUR 4, CBZ 3, B 3.
  - Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_read/mem_write stay asserted, with stable i_or_d, for every cycle until mem_ready is sampled high. mem_ready outside a memory state is ignored.
- run=0 mid-instruction does not abort; the instruction completes and the FSM parks in IDLE. IDLE→FETCH takes 1 cycle after run is sampled high.
- The retired update and the next-state transition occur on the same edge.

## Test plan
- ADD opcode 10001011000, run=1, mem_ready=1 → states 1,2,7,8,1; reg_write=1 only in state 8; alu_op=10 in state 7; retired 0→1.
- LDUR with mem_ready low 2 cycles in MEM_READ → mem_read and i_or_d held high 3 cycles; 7 cycles total; mem_to_reg=1 in MEM_WB.
- STUR then CBZ → reg_to_loc=1 during both; CBZ asserts pc_write_cond=1, pc_source=1 for exactly 1 cycle; retired=2.
- Opcode 11111111111 → HALT after DECODE, halted=1, retired unchanged; toggling run has no effect; reset low → state=0, halted=0.
- run dropped during R_EXEC → R_WB completes, then state=0 (IDLE); run=1 → FETCH on the next edge.
- COUNT_WIDTH=4, 16 B instructions → retired wraps 15→0; reset asserted mid-FETCH → outputs 0 asynchronously.
